// File: rtl/pe_issue_scheduler.sv
// Issue sequencer for the sparse-conv PE: walks weights (outer) x feature groups (inner),
// presents one index pair per beat under valid/ready, then drains the PE pipeline.
module pe_issue_scheduler #(
   parameter int unsigned double_word_length = 16,
   parameter int unsigned group_size         = 4,
   parameter int unsigned pipe_depth         = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [double_word_length-1:0] in_channel,
   input  logic [double_word_length-1:0] feature_valid_num,
   input  logic [double_word_length-1:0] weight_valid_num,
   input  logic                          pe_ready,
   output logic                          issue_valid,
   output logic [double_word_length-1:0] curr_weight,
   output logic [double_word_length-1:0] curr_pixel,
   output logic [3:0]                    lane_mask,
   output logic                          last,
   output logic [double_word_length-1:0] channel_out,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned DW       = double_word_length;
   localparam int unsigned GrpShift = $clog2(group_size);
   localparam int unsigned CntW     = (pipe_depth > 1) ? $clog2(pipe_depth) : 1;

   typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StDone} state_t;

   state_t          state;
   logic [DW-1:0]   f_q;
   logic [DW-1:0]   w_q;
   logic [DW:0]     g_q;
   logic [3:0]      tail_mask_q;
   logic            tail_q;
   logic [CntW-1:0] drain_cnt;

   logic [DW:0]     g_wide;
   logic            on_last_group;
   logic            last_beat;

   // One extra bit so that F = all-ones does not wrap when rounding up.
   always_comb begin
      g_wide        = ({1'b0, f_q} + (DW+1)'(group_size - 1)) >> GrpShift;
      on_last_group = ({1'b0, curr_pixel} == (g_q - 1'b1));
      last_beat     = (curr_weight == (w_q - 1'b1)) && on_last_group;
   end

   always_comb begin
      last      = issue_valid && last_beat;
      lane_mask = 4'h0;
      if (issue_valid) begin
         lane_mask = (on_last_group && tail_q) ? tail_mask_q : 4'hf;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= StIdle;
         f_q         <= '0;
         w_q         <= '0;
         g_q         <= '0;
         tail_mask_q <= '0;
         tail_q      <= 1'b0;
         drain_cnt   <= '0;
         curr_weight <= '0;
         curr_pixel  <= '0;
         channel_out <= '0;
         issue_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               done <= 1'b0;
               if (start) begin
                  f_q         <= feature_valid_num;
                  w_q         <= weight_valid_num;
                  channel_out <= in_channel;
                  busy        <= 1'b1;
                  state       <= StLoad;
               end
            end
            StLoad: begin
               g_q         <= g_wide;
               tail_q      <= |f_q[1:0];
               tail_mask_q <= (4'b0001 << f_q[1:0]) - 4'b0001;
               curr_weight <= '0;
               curr_pixel  <= '0;
               drain_cnt   <= '0;
               if (w_q == '0 || f_q == '0) begin
                  state <= StDrain;
               end else begin
                  issue_valid <= 1'b1;
                  state       <= StRun;
               end
            end
            StRun: begin
               if (pe_ready) begin
                  if (on_last_group) begin
                     curr_pixel  <= '0;
                     curr_weight <= curr_weight + 1'b1;
                  end else begin
                     curr_pixel <= curr_pixel + 1'b1;
                  end
                  if (last_beat) begin
                     issue_valid <= 1'b0;
                     state       <= StDrain;
                  end
               end
            end
            StDrain: begin
               if (drain_cnt == CntW'(pipe_depth - 1)) begin
                  done  <= 1'b1;
                  state <= StDone;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            StDone: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_issue_scheduler.sv
// Scoreboard bench for pe_issue_scheduler: stimulus queues expected beats from a loop model,
// a negedge monitor compares presented beats and done timing.
module tb_pe_issue_scheduler;

   localparam int DW = 16;
   localparam int P  = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] in_channel = '0;
   logic [DW-1:0] feature_valid_num = '0;
   logic [DW-1:0] weight_valid_num = '0;
   logic          pe_ready = 1'b0;
   logic          issue_valid;
   logic [DW-1:0] curr_weight;
   logic [DW-1:0] curr_pixel;
   logic [3:0]    lane_mask;
   logic          last;
   logic [DW-1:0] channel_out;
   logic          busy;
   logic          done;

   pe_issue_scheduler #(
      .double_word_length(DW),
      .group_size        (4),
      .pipe_depth        (P)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .in_channel       (in_channel),
      .feature_valid_num(feature_valid_num),
      .weight_valid_num (weight_valid_num),
      .pe_ready         (pe_ready),
      .issue_valid      (issue_valid),
      .curr_weight      (curr_weight),
      .curr_pixel       (curr_pixel),
      .lane_mask        (lane_mask),
      .last             (last),
      .channel_out      (channel_out),
      .busy             (busy),
      .done             (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int w;
      int p;
      int mask;
      bit last;
   } beat_t;

   beat_t exp_q[$];
   beat_t mon_b;
   int    cyc = 0;
   int    total = 0;
   int    bad = 0;
   int    ready_mode = 0;
   int    exp_done = -1;
   int    done_seen = 0;
   int    runs_done = 0;
   int    accepted = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: nested loops over weights and ceil(F/4) groups, tail lanes from F mod 4.
   function automatic void model(input int f, input int w);
      int g;
      int t;
      beat_t b;
      g = (f + 3) / 4;
      t = f % 4;
      for (int wi = 0; wi < w; wi++) begin
         for (int gi = 0; gi < g; gi++) begin
            b.w    = wi;
            b.p    = gi;
            b.mask = (gi == g - 1 && t != 0) ? (1 << t) - 1 : 15;
            b.last = (wi == w - 1) && (gi == g - 1);
            exp_q.push_back(b);
         end
      end
   endfunction

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       pe_ready = 1'b1;
         1:       pe_ready = (cyc % 3 == 0);
         default: pe_ready = ($urandom_range(0, 9) < 7);
      endcase
   end

   // Monitor: compare presented beat with queue head every cycle (stalls included).
   always @(negedge clk) begin
      if (rst) begin
         if (issue_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 1, 0);
            end else begin
               mon_b = exp_q[0];
               check("curr_weight", curr_weight, mon_b.w);
               check("curr_pixel", curr_pixel, mon_b.p);
               check("lane_mask", lane_mask, mon_b.mask);
               check("last", last, mon_b.last);
               if (pe_ready) begin
                  void'(exp_q.pop_front());
                  accepted++;
                  if (mon_b.last) exp_done = cyc + 1 + P;
               end
            end
         end
         if (done) begin
            done_seen++;
            check("done_cycle", cyc, exp_done);
            exp_done = -1;
         end
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_issue_valid"}, issue_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_curr_weight"}, curr_weight, 0);
      check({tag, "_curr_pixel"}, curr_pixel, 0);
      check({tag, "_lane_mask"}, lane_mask, 0);
      check({tag, "_last"}, last, 0);
   endtask

   task automatic run(input int f, input int w, input int ch, input bit chk_lat,
                      input bit inject);
      int s;
      int n;
      @(posedge clk);
      #1;
      start = 1'b1;
      feature_valid_num = DW'(f);
      weight_valid_num = DW'(w);
      in_channel = DW'(ch);
      s = cyc;
      n = w * ((f + 3) / 4);
      model(f, w);
      if (n == 0) exp_done = s + 2 + P;
      @(posedge clk);
      #1;
      start = 1'b0;
      feature_valid_num = DW'($urandom);
      weight_valid_num = DW'($urandom);
      in_channel = DW'($urandom);
      @(negedge clk);
      check("busy_after_start", busy, 1);
      if (inject) begin
         @(posedge clk);
         #1;
         start = 1'b1;
         feature_valid_num = DW'(f + 5);
         weight_valid_num = DW'(w + 1);
         in_channel = DW'(ch + 1);
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      for (int k = 0; k < 40000; k++) begin
         @(negedge clk);
         if (done) break;
      end
      check("done_reached", done, 1);
      if (chk_lat) check("done_latency", cyc - s, 2 + n + P);
      check("channel_out", channel_out, ch);
      check("queue_drained", exp_q.size(), 0);
      runs_done++;
      @(negedge clk);
      check("busy_after_done", busy, 0);
      check("idle_issue_valid", issue_valid, 0);
      if (inject) begin
         repeat (4) @(negedge clk);
         check("no_queued_run", busy, 0);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      check("reset_channel_out", channel_out, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      ready_mode = 0;
      run(8, 3, 17, 1, 0);
      run(5, 2, 3, 1, 0);
      run(0, 7, 4, 1, 0);
      run(9, 0, 5, 1, 0);
      ready_mode = 1;
      run(4, 2, 6, 0, 0);
      ready_mode = 0;
      run(8, 3, 9, 1, 1);

      // Abort mid-run at the third beat, then restart cleanly.
      @(posedge clk);
      #1;
      start = 1'b1;
      feature_valid_num = 16'd8;
      weight_valid_num = 16'd3;
      in_channel = 16'd21;
      accepted = 0;
      model(8, 3);
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (accepted >= 2) break;
      end
      #1;
      rst = 1'b0;
      #1;
      check_zero("abort");
      exp_q.delete();
      exp_done = -1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      run(8, 3, 22, 1, 0);

      // Wide F: group count must not wrap.
      run(16'hffff, 1, 7, 1, 0);

      for (int i = 0; i < 16; i++) begin
         ready_mode = (i % 4 == 0) ? 0 : 2;
         run($urandom_range(0, 21), $urandom_range(0, 4), $urandom_range(0, 65535),
             ready_mode == 0, 0);
      end

      check("done_pulse_count", done_seen, runs_done);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pe_issue_scheduler.md
# pe_issue_scheduler

Sequencing controller for the sparse-convolution PE datapath. It walks the Cartesian product of non-zero weights and non-zero feature groups (4 features per group) for one input channel. Each cycle it issues a `curr_weight` / `curr_pixel` index pair, with a lane mask, to the PE slice logic under a valid/ready handshake. It then waits out the PE pipeline and reports completion to the layer controller.

## Interface
Parameters:
- `double_word_length`, 16: width of counts, indices and channel number.
- `group_size`, 4: features consumed per issue beat. Fixed to 4; this matches the PE 4-lane feature slice.
- `pipe_depth`, 3: PE accumulate latency in cycles, from accepted beat to result settled.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset. Assertion clears all state immediately; release is synchronous to `clk`.
- `start`, in, 1: one-cycle request to process a channel. Sampled only in IDLE.
- `in_channel`, in, `double_word_length`: channel number, latched on `start`.
- `feature_valid_num`, in, `double_word_length`: count F of non-zero features, latched on `start`.
- `weight_valid_num`, in, `double_word_length`: count W of non-zero weights, latched on `start`.
- `pe_ready`, in, 1: PE can accept a beat this cycle.
- `issue_valid`, out, 1: an index pair is presented.
- `curr_weight`, out, `double_word_length`: weight index, range 0..W-1.
- `curr_pixel`, out, `double_word_length`: feature group index, range 0..G-1.
- `lane_mask`, out, 4: valid lanes within the current group; bit i means feature 4·curr_pixel+i is valid.
- `last`, out, 1: the presented beat is the final beat of the channel.
- `channel_out`, out, `double_word_length`: latched channel number.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle completion pulse.

## Operation
Group count and tail:
- G = ceil(F/4), computed as (F+3)>>2 with a `double_word_length`+1-bit intermediate so that F=0xFFFF does not wrap.
- Tail count T = F mod 4. The lane mask is 4'b1111, except on beats with curr_pixel = G-1 and T≠0, where it is (1<<T)-1.

Issue order:
- The weight index is the outer loop and the pixel group is the inner loop: (w0,g0), (w0,g1), …, (w0,gG-1), (w1,g0), …
- There are exactly W·G beats per channel.

States:
- IDLE: `busy`=0. On `start`, latch F, W and `in_channel`, then go to LOAD.
- LOAD: compute G, T and the mask, and clear both indices.
  - If W=0 or F=0, go to DRAIN with zero beats issued.
  - Otherwise go to RUN.
- RUN: `issue_valid`=1.
  - A beat is accepted on a rising edge where `issue_valid` and `pe_ready` are both 1.
  - On acceptance: if curr_pixel = G-1, set curr_pixel to 0 and increment curr_weight; otherwise increment curr_pixel.
  - If the accepted beat has `last`=1, go to DRAIN instead.
- DRAIN: `issue_valid`=0. Count `pipe_depth` cycles, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.

`last` is combinational: last = (curr_weight = W-1) and (curr_pixel = G-1), qualified by RUN.

`start` is ignored while `busy`=1. No request is queued.

## Timing
Reset values:
- All outputs are 0, state is IDLE, and all indices and latched values are 0.

Handshake:
- While `issue_valid`=1 and `pe_ready`=0, `curr_weight`, `curr_pixel`, `lane_mask` and `last` hold stable.
- `issue_valid` never drops in RUN until the last beat is accepted.
- There is no combinational path from `pe_ready` to `issue_valid`.

Latency and throughput:
- `start` is in cycle 0. LOAD occupies cycle 1. The first `issue_valid` is in cycle 2.
- With `pe_ready` held at 1, one beat is accepted per cycle.
- The last beat is accepted at the end of cycle 2+W·G-1. DRAIN then occupies cycles 2+W·G through 2+W·G+`pipe_depth`-1. `done` is high in cycle 2+W·G+`pipe_depth`.
- Zero-work channel: `start` in cycle 0, LOAD in cycle 1, DRAIN for `pipe_depth` cycles, `done` in cycle 2+`pipe_depth`. No `issue_valid` is asserted.
- `busy` rises in the cycle after `start` and falls in the cycle after `done`.

Reset mid-operation:
- Any state returns to IDLE asynchronously.
- `issue_valid` and `done` drop immediately. No `done` is produced for the aborted channel.

A `start` coincident with the `done` cycle is ignored, because the block is not yet in IDLE.

## Test plan
- F=8, W=3, `pe_ready`=1: 6 beats in order (0,0)(0,1)(1,0)(1,1)(2,0)(2,1), every `lane_mask`=1111, `last` only on (2,1), `done` in cycle 2+6+3 = 11.
- F=5, W=2: G=2. Beats with curr_pixel=1 carry `lane_mask`=0001 and all other beats carry 1111; exactly 4 beats.
- F=0, W=7, and separately F=9, W=0: no `issue_valid`, `done` in cycle 5 (`pipe_depth`=3), `busy` high in cycles 1–5.
- F=4, W=2, `pe_ready` toggling 1,0,0,1,…: indices stay stable during stalls, exactly 2 accepted beats, `done` exactly 3 cycles after the final acceptance.
- Reset asserted during RUN at beat 3 of 6: all outputs 0 in the same cycle. A new `start` after release restarts from index (0,0).
- `start` pulsed during RUN with different F, W and channel: no effect on the current counts or `channel_out`, no queued second run.
